// File: rtl/cvp14_burst_dram_pkg.sv
// Shared types and defaults for the CVP14 burst DRAM model.
package cvp14_pkg;

    localparam int unsigned CVP14_DATA_W = 16;
    localparam int unsigned CVP14_ADDR_W = 16;
    localparam int unsigned CVP14_VLEN   = 16;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST
    } dram_state_t;

    // BurstLen width; a 1-beat-only configuration still needs a 1-bit field.
    function automatic int unsigned len_width(input int unsigned burst_max);
        return (burst_max > 1) ? $clog2(burst_max) : 1;
    endfunction

endpackage

// File: rtl/cvp14_burst_dram_if.sv
// Request/response bus between a CVP14 master and the burst DRAM model.
interface cvp14_burst_dram_if
    import cvp14_pkg::*;
#(
    parameter int unsigned DATA_W    = CVP14_DATA_W,
    parameter int unsigned ADDR_W    = CVP14_ADDR_W,
    parameter int unsigned BURST_MAX = CVP14_VLEN
);

    localparam int unsigned LEN_W = len_width(BURST_MAX);

    logic              RD;
    logic              WR;
    logic [ADDR_W-1:0] Addr;
    logic [LEN_W-1:0]  BurstLen;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] DataOut;
    logic              DataValid;
    logic              Busy;

    modport master (
        output RD, WR, Addr, BurstLen, DataIn,
        input  DataOut, DataValid, Busy
    );

    modport slave (
        input  RD, WR, Addr, BurstLen, DataIn,
        output DataOut, DataValid, Busy
    );

endinterface

// File: rtl/cvp14_dram_array.sv
// 1R1W synchronous storage array with a registered read port.
module cvp14_dram_array #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] Memory [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            Memory[waddr] <= wdata;
        end
        rdata <= Memory[raddr];
    end

endmodule

// File: rtl/cvp14_burst_dram.sv
// Burst DRAM controller: accepts one read or write burst at a time, with a
// configurable read latency, in front of a registered-read storage array.
module cvp14_burst_dram
    import cvp14_pkg::*;
#(
    parameter int unsigned DATA_W     = CVP14_DATA_W,
    parameter int unsigned ADDR_W     = CVP14_ADDR_W,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned BURST_MAX  = CVP14_VLEN
) (
    input logic              Clk1,
    input logic              Reset,
    cvp14_burst_dram_if.slave bus
);

    localparam int unsigned LEN_W     = len_width(BURST_MAX);
    localparam logic [3:0]  WAIT_LAST = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;

    dram_state_t           state_q, state_d;
    logic [DEPTH_LOG2-1:0] a0_q, a0_d;
    logic [LEN_W-1:0]      len_m1_q, len_m1_d;
    logic [LEN_W-1:0]      beat_q, beat_d;
    logic [3:0]            wait_q, wait_d;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr, mem_raddr, addr_lo;
    logic [DATA_W-1:0]     mem_wdata, mem_rdata;
    logic                  data_valid;

    assign addr_lo = bus.Addr[DEPTH_LOG2-1:0];

    if (ADDR_W > DEPTH_LOG2) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.Addr[ADDR_W-1:DEPTH_LOG2];
    end

    // The array read is issued one cycle ahead of the beat it feeds, so the
    // read address always leads the beat counter by one word.
    always_comb begin
        state_d   = state_q;
        a0_d      = a0_q;
        len_m1_d  = len_m1_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        mem_we    = 1'b0;
        mem_waddr = addr_lo;
        mem_wdata = bus.DataIn;
        mem_raddr = addr_lo;

        unique case (state_q)
            IDLE: begin
                if (bus.WR) begin
                    mem_we   = 1'b1;
                    a0_d     = addr_lo;
                    len_m1_d = bus.BurstLen;
                    beat_d   = LEN_W'(1);
                    if (bus.BurstLen != '0) begin
                        state_d = WR_BURST;
                    end
                end else if (bus.RD) begin
                    a0_d     = addr_lo;
                    len_m1_d = bus.BurstLen;
                    beat_d   = '0;
                    wait_d   = '0;
                    state_d  = (RD_LAT > 1) ? RD_WAIT : RD_BURST;
                end
            end
            RD_WAIT: begin
                mem_raddr = a0_q;
                if (wait_q == WAIT_LAST) begin
                    state_d = RD_BURST;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            RD_BURST: begin
                mem_raddr = a0_q + DEPTH_LOG2'(beat_q) + DEPTH_LOG2'(1);
                if (beat_q == len_m1_q) begin
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + LEN_W'(1);
                end
            end
            WR_BURST: begin
                mem_we    = 1'b1;
                mem_waddr = a0_q + DEPTH_LOG2'(beat_q);
                if (beat_q == len_m1_q) begin
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + LEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A beat landing on a reset edge is aborted, not committed.
        if (Reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q  <= IDLE;
            a0_q     <= '0;
            len_m1_q <= '0;
            beat_q   <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            a0_q     <= a0_d;
            len_m1_q <= len_m1_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
        end
    end

    cvp14_dram_array #(
        .DATA_W    (DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (Clk1),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .raddr(mem_raddr),
        .rdata(mem_rdata)
    );

    assign data_valid    = (state_q == RD_BURST);
    assign bus.DataValid = data_valid;
    assign bus.Busy      = (state_q != IDLE);
    assign bus.DataOut   = data_valid ? mem_rdata : '0;

endmodule
